mac_iter_sched: RTL
===================

Name: mac_iter_sched

Overview:
Hardwired iteration scheduler for the MAC engine; an alternative to the microcode path when no programmable sequencing is needed.
- Takes a job (iteration count, vector length, stride, four base addresses) from the control FSM.
- For each iteration, issues streamer commands for a, b, (c), d on one shared command channel.
- Then pulses the engine start and waits for engine done. Pulses done_o after the last iteration.

Parameters:
ADDR_WIDTH, 32, byte-address width of streamer commands
CNT_WIDTH, 12, width of iteration counter and vector length
LEN_WIDTH, 16, width of cmd_len_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
clear_i  in  1  synchronous soft clear (abort job)
start_i  in  1  job start pulse
nb_iter_i  in  CNT_WIDTH  number of iterations (0 allowed)
len_i  in  CNT_WIDTH  vector length in words per iteration
stride_i  in  ADDR_WIDTH  address increment per iteration
simple_mul_i  in  1  1: no c stream, d length = len; 0: c stream issued, d length = 1
base_a_i, base_b_i, base_c_i, base_d_i  in  ADDR_WIDTH each  stream base addresses
cmd_valid_o  out  1  command valid
cmd_ready_i  in  1  streamer accepts command
cmd_stream_o  out  2  0=a, 1=b, 2=c, 3=d (sink)
cmd_addr_o  out  ADDR_WIDTH  stream start address
cmd_len_o  out  LEN_WIDTH  words to transfer (len zero-extended)
eng_start_o  out  1  one-cycle engine start pulse
eng_done_i  in  1  engine finished current iteration
busy_o  out  1  job in progress
done_o  out  1  one-cycle job-complete pulse
iter_o  out  CNT_WIDTH  index of current iteration

Behaviour:
- Reset (rst_i): state IDLE; all outputs 0; counters and address accumulators 0.
- Job latch: in IDLE, start_i=1 latches every config input. Config changes during a job have no effect.
- States: IDLE, ISSUE, START, WAIT, DONE.
- IDLE→ISSUE on start_i when nb_iter_i≠0. IDLE→DONE on start_i when nb_iter_i=0.
- ISSUE: cmd_valid_o=1; streams presented in order a, b, c, d, skipping c when simple_mul=1.
  - Command fields stay stable while cmd_valid_o && !cmd_ready_i.
  - Each handshake advances to the next stream; after d is accepted, go to START.
- START: eng_start_o=1 for exactly one cycle; go to WAIT.
- WAIT: on eng_done_i, increment iter.
  - If iter+1==nb_iter, go to DONE.
  - Otherwise add stride to all four address accumulators and return to ISSUE.
- DONE: done_o=1 for one cycle; busy_o=0 in this cycle; go to IDLE.
- busy_o=1 in ISSUE, START and WAIT.
- Latency:
  - start at cycle 0 → cycle 1: busy_o=1 and first cmd_valid_o=1.
  - eng_done_i of the last iteration at cycle t → done_o at t+1.
- Addresses: iteration k uses base_x + k*stride, built by accumulation only (no multiplier), modulo 2^ADDR_WIDTH.
- cmd_len_o = len for a/b/c. For d: len if simple_mul, else 1.
- Ignored inputs: start_i while not IDLE; eng_done_i outside WAIT.
- Clear/reset precedence:
  - clear_i or rst_i mid-job: next cycle is IDLE with all outputs 0, no done_o.
  - clear_i wins over a simultaneous start_i.
  - clear_i in DONE suppresses done_o.
- len_i=0: commands still issued with cmd_len_o=0.

Optional Feature:
Macro MAC_ITER_SCHED_PERF_EN.
- Defined: adds output perf_busy_o [31:0] and output perf_stall_o [31:0].
  - perf_busy_o counts cycles with busy_o=1.
  - perf_stall_o counts cycles with cmd_valid_o && !cmd_ready_i.
  - Both zeroed on reset, clear_i, or job start; both saturate at 2^32-1.
- Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mac_package gains:
  - sched_state_t enum
  - stream id constants MAC_STREAM_A/B/C/D
  - struct ctrl_sched_t carrying the config inputs (start, nb_iter, len, stride, simple_mul, bases)
  - struct flags_sched_t carrying busy, done, iter
- One natural sub-module: mac_iter_sched_addr, holding the four address accumulators with load-base and add-stride controls.

Test Plan:
1. nb_iter=3, len=8, stride=0x40, simple_mul=0, bases a=0x1000, b=0x2000, c=0x3000, d=0x4000, cmd_ready_i=1, eng_done_i 5 cycles after each eng_start_o → 12 commands; iteration 2 addresses 0x1080/0x2080/0x3080/0x4080; d cmd_len_o=1; exactly one done_o, one cycle after the third eng_done_i.
2. simple_mul=1, nb_iter=2, len=4 → stream sequence a,b,d,a,b,d; no stream-2 command; d cmd_len_o=4.
3. nb_iter=0 with start_i → done_o in cycle 1; no cmd_valid_o, no eng_start_o, busy_o stays 0.
4. cmd_ready_i low for 7 cycles on stream b → cmd_stream_o=1 and cmd_addr_o held stable throughout; with perf enabled, perf_stall_o=7.
5. clear_i asserted in WAIT of iteration 1 → IDLE next cycle; no done_o; a fresh start runs iteration 0 from the base addresses.
6. base_a=0xFFFFFFC0, stride=0x40, nb_iter=2 → iteration 1 address a=0x00000000 (wrap).

Source files
------------

// File: rtl/mac_package.sv
// Shared types and constants for the MAC engine control path: iteration
// scheduler states, streamer ids and the scheduler config/status bundles.
package mac_package;

    localparam int MAC_ADDR_WIDTH = 32;
    localparam int MAC_CNT_WIDTH  = 12;
    localparam int MAC_LEN_WIDTH  = 16;

    localparam logic [1:0] MAC_STREAM_A = 2'd0;
    localparam logic [1:0] MAC_STREAM_B = 2'd1;
    localparam logic [1:0] MAC_STREAM_C = 2'd2;
    localparam logic [1:0] MAC_STREAM_D = 2'd3;

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_ISSUE,
        SCHED_START,
        SCHED_WAIT,
        SCHED_DONE
    } sched_state_t;

    typedef struct packed {
        logic                      start;
        logic [MAC_CNT_WIDTH-1:0]  nb_iter;
        logic [MAC_CNT_WIDTH-1:0]  len;
        logic [MAC_ADDR_WIDTH-1:0] stride;
        logic                      simple_mul;
        logic [MAC_ADDR_WIDTH-1:0] base_a;
        logic [MAC_ADDR_WIDTH-1:0] base_b;
        logic [MAC_ADDR_WIDTH-1:0] base_c;
        logic [MAC_ADDR_WIDTH-1:0] base_d;
    } ctrl_sched_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [MAC_CNT_WIDTH-1:0] iter;
    } flags_sched_t;

    // Stream order within one iteration; c is skipped for a plain multiply.
    function automatic logic [1:0] next_stream(input logic [1:0] cur, input logic simple_mul);
        case (cur)
            MAC_STREAM_A: next_stream = MAC_STREAM_B;
            MAC_STREAM_B: next_stream = simple_mul ? MAC_STREAM_D : MAC_STREAM_C;
            MAC_STREAM_C: next_stream = MAC_STREAM_D;
            default:      next_stream = MAC_STREAM_A;
        endcase
    endfunction

endpackage

// File: rtl/mac_iter_sched_addr.sv
// Four stream address accumulators: loaded with the job bases, then advanced
// by the latched stride once per iteration (no multiplier).
module mac_iter_sched_addr
    import mac_package::*;
#(
    parameter int ADDR_WIDTH = MAC_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  add_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    input  logic [ADDR_WIDTH-1:0] base_c_i,
    input  logic [ADDR_WIDTH-1:0] base_d_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [1:0]            sel_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] acc_q [4];
    logic [ADDR_WIDTH-1:0] stride_q;

    // NOTE: this small array is ordinary state, so it is reset like any flop; large RAMs would not be.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            stride_q <= '0;
        end else if (load_i) begin
            acc_q[MAC_STREAM_A] <= base_a_i;
            acc_q[MAC_STREAM_B] <= base_b_i;
            acc_q[MAC_STREAM_C] <= base_c_i;
            acc_q[MAC_STREAM_D] <= base_d_i;
            stride_q            <= stride_i;
        end else if (add_i) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= acc_q[i] + stride_q;
        end
    end

    assign addr_o = acc_q[sel_i];

endmodule

// File: rtl/mac_iter_sched.sv
// Hardwired MAC iteration scheduler: per iteration issues a/b/(c)/d streamer
// commands, starts the engine and waits for it. Optional perf counters: MAC_ITER_SCHED_PERF_EN.
module mac_iter_sched
    import mac_package::*;
#(
    parameter int ADDR_WIDTH = MAC_ADDR_WIDTH,
    parameter int CNT_WIDTH  = MAC_CNT_WIDTH,
    parameter int LEN_WIDTH  = MAC_LEN_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  nb_iter_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic                  simple_mul_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    input  logic [ADDR_WIDTH-1:0] base_c_i,
    input  logic [ADDR_WIDTH-1:0] base_d_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [1:0]            cmd_stream_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [LEN_WIDTH-1:0]  cmd_len_o,
    output logic                  eng_start_o,
    input  logic                  eng_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  iter_o
`ifdef MAC_ITER_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_busy_o,
    output logic [31:0]           perf_stall_o
`endif
);

    sched_state_t          state_q, state_d;
    ctrl_sched_t           ctrl;
    flags_sched_t          flags;
    logic [CNT_WIDTH-1:0]  nb_iter_q, len_q, iter_q;
    logic                  simple_mul_q;
    logic [1:0]            stream_q;
    logic                  job_start, cmd_fire, iter_done, last_iter;
    logic [ADDR_WIDTH-1:0] stream_addr;

    always_comb begin
        ctrl.start      = start_i;
        ctrl.nb_iter    = MAC_CNT_WIDTH'(nb_iter_i);
        ctrl.len        = MAC_CNT_WIDTH'(len_i);
        ctrl.stride     = MAC_ADDR_WIDTH'(stride_i);
        ctrl.simple_mul = simple_mul_i;
        ctrl.base_a     = MAC_ADDR_WIDTH'(base_a_i);
        ctrl.base_b     = MAC_ADDR_WIDTH'(base_b_i);
        ctrl.base_c     = MAC_ADDR_WIDTH'(base_c_i);
        ctrl.base_d     = MAC_ADDR_WIDTH'(base_d_i);
    end

    assign job_start = (state_q == SCHED_IDLE) && ctrl.start && !clear_i;
    assign cmd_fire  = (state_q == SCHED_ISSUE) && cmd_ready_i;
    assign iter_done = (state_q == SCHED_WAIT) && eng_done_i;
    assign last_iter = (iter_q + CNT_WIDTH'(1)) == nb_iter_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= SCHED_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCHED_IDLE:  if (ctrl.start) state_d = (ctrl.nb_iter == '0) ? SCHED_DONE : SCHED_ISSUE;
            SCHED_ISSUE: if (cmd_ready_i && stream_q == MAC_STREAM_D) state_d = SCHED_START;
            SCHED_START: state_d = SCHED_WAIT;
            SCHED_WAIT:  if (eng_done_i) state_d = last_iter ? SCHED_DONE : SCHED_ISSUE;
            SCHED_DONE:  state_d = SCHED_IDLE;
            default:     state_d = SCHED_IDLE;
        endcase
        if (clear_i) state_d = SCHED_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            nb_iter_q    <= '0;
            len_q        <= '0;
            simple_mul_q <= 1'b0;
            iter_q       <= '0;
            stream_q     <= MAC_STREAM_A;
        end else begin
            if (job_start) begin
                nb_iter_q    <= CNT_WIDTH'(ctrl.nb_iter);
                len_q        <= CNT_WIDTH'(ctrl.len);
                simple_mul_q <= ctrl.simple_mul;
                iter_q       <= '0;
            end else if (iter_done) begin
                iter_q <= iter_q + CNT_WIDTH'(1);
            end else if (state_q == SCHED_DONE) begin
                iter_q <= '0;
            end
            if (job_start || (iter_done && !last_iter)) stream_q <= MAC_STREAM_A;
            else if (cmd_fire)                          stream_q <= next_stream(stream_q, simple_mul_q);
        end
    end

    mac_iter_sched_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .load_i   (job_start),
        .add_i    (iter_done && !last_iter),
        .base_a_i (ADDR_WIDTH'(ctrl.base_a)),
        .base_b_i (ADDR_WIDTH'(ctrl.base_b)),
        .base_c_i (ADDR_WIDTH'(ctrl.base_c)),
        .base_d_i (ADDR_WIDTH'(ctrl.base_d)),
        .stride_i (ADDR_WIDTH'(ctrl.stride)),
        .sel_i    (stream_q),
        .addr_o   (stream_addr)
    );

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        cmd_valid_o  = 1'b0;
        cmd_stream_o = '0;
        cmd_addr_o   = '0;
        cmd_len_o    = '0;
        eng_start_o  = 1'b0;
        flags.busy   = (state_q == SCHED_ISSUE) || (state_q == SCHED_START) || (state_q == SCHED_WAIT);
        flags.done   = (state_q == SCHED_DONE) && !clear_i;
        flags.iter   = MAC_CNT_WIDTH'(iter_q);
        case (state_q)
            SCHED_ISSUE: begin
                cmd_valid_o  = 1'b1;
                cmd_stream_o = stream_q;
                cmd_addr_o   = stream_addr;
                cmd_len_o    = (stream_q == MAC_STREAM_D && !simple_mul_q) ? LEN_WIDTH'(1) : LEN_WIDTH'(len_q);
            end
            SCHED_START: eng_start_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o = flags.busy;
    assign done_o = flags.done;
    assign iter_o = CNT_WIDTH'(flags.iter);

`ifdef MAC_ITER_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || job_start) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (flags.busy && perf_busy_q != '1)                 perf_busy_q  <= perf_busy_q + 32'd1;
            if (cmd_valid_o && !cmd_ready_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_o  = perf_busy_q;
    assign perf_stall_o = perf_stall_q;
`else
    // Counters are compiled out; the scheduler itself is unchanged.
`endif

endmodule
